// File: rtl/psat_au.sv
// rtl/psat_au.sv - two-stage pipelined saturating add/sub unit with packed-lane mode
// Stage 1 holds operands; stage 2 holds the saturated result and flags.

module psat_au #(
    parameter int WIDTH = 16,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             n,
    output logic             z,
    output logic             c,
    input  logic             clr_sat,
    output logic             sat_sticky
);

    localparam int NL = WIDTH / LANE;

    logic             s1_valid_q;
    logic [1:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             v_q, v_d, n_q, n_d, z_q, z_d, c_q, c_d;
    logic             sat_q, sat_d;
    logic             s2_ready;

    assign s2_ready = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // Operand registers carry no reset: their contents only matter under s1_valid_q.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_op_q <= op;
            s1_a_q  <= a;
            s1_b_q  <= b;
        end
    end

    logic             sub, packed_op;
    logic [WIDTH-1:0] bx;
    assign sub       = s1_op_q[0];
    assign packed_op = s1_op_q[1];
    assign bx        = sub ? ~s1_b_q : s1_b_q;

    logic [WIDTH:0]   fsum;
    logic             fv;
    logic [WIDTH-1:0] fres;
    assign fsum = {1'b0, s1_a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign fv   = (s1_a_q[WIDTH-1] == bx[WIDTH-1]) && (fsum[WIDTH-1] != s1_a_q[WIDTH-1]);
    // On overflow the wrapped sign is the inverse of the true sign.
    assign fres = fv ? {~fsum[WIDTH-1], {(WIDTH-1){fsum[WIDTH-1]}}} : fsum[WIDTH-1:0];

    logic [NL-1:0]    lv, ln, lc;
    logic [WIDTH-1:0] pres;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [LANE-1:0] la, lb;
        logic [LANE:0]   ls;
        assign la    = s1_a_q[l*LANE +: LANE];
        assign lb    = bx[l*LANE +: LANE];
        assign ls    = {1'b0, la} + {1'b0, lb} + {{LANE{1'b0}}, sub};
        assign lv[l] = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
        assign ln[l] = ls[LANE-1] ^ lv[l];
        assign lc[l] = ls[LANE];
        assign pres[l*LANE +: LANE] = lv[l] ? {~ls[LANE-1], {(LANE-1){ls[LANE-1]}}}
                                            : ls[LANE-1:0];
    end

    always_comb begin
        result_d = packed_op ? pres : fres;
        v_d      = packed_op ? |lv : fv;
        n_d      = packed_op ? ln[NL-1] : (fsum[WIDTH-1] ^ fv);
        c_d      = packed_op ? lc[NL-1] : fsum[WIDTH];
        z_d      = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                v_q      <= v_d;
                n_q      <= n_d;
                z_q      <= z_d;
                c_q      <= c_d;
            end
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (out_valid_q && out_ready && v_q) begin
            sat_d = 1'b1;
        end else if (clr_sat) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign v          = v_q;
    assign n          = n_q;
    assign z          = z_q;
    assign c          = c_q;
    assign sat_sticky = sat_q;

endmodule

// File: tb/tb_psat_au.sv
// tb/tb_psat_au.sv - scoreboard bench for psat_au with randomized traffic and backpressure

module tb_psat_au;

    typedef struct packed {
        logic [15:0] r;
        logic        v;
        logic        n;
        logic        z;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        v, n, z, c;
    logic        clr_sat = 1'b0;
    logic        sat_sticky;

    int   checks = 0;
    int   passed = 0;
    exp_t q[$];
    logic exp_sticky = 1'b0;
    logic dir_valid = 1'b0;
    exp_t dir_exp;
    logic rand_bp = 1'b0;

    psat_au #(.WIDTH(16), .LANE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .v(v), .n(n), .z(z), .c(c),
        .clr_sat(clr_sat), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: signed integer arithmetic clamped to the lane range.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   L, nl, mask, ua, ub, sa, sb, t, s, mx, mn, res;
        e   = '0;
        res = 0;
        L    = o[1] ? 8 : 16;
        nl   = 16 / L;
        mask = (1 << L) - 1;
        mx   = (1 << (L - 1)) - 1;
        mn   = -(1 << (L - 1));
        for (int l = 0; l < nl; l++) begin
            ua = (int'(x) >> (l * L)) & mask;
            ub = (int'(y) >> (l * L)) & mask;
            sa = (ua > mx) ? ua - (1 << L) : ua;
            sb = (ub > mx) ? ub - (1 << L) : ub;
            t  = o[0] ? sa - sb : sa + sb;
            s  = (t > mx) ? mx : ((t < mn) ? mn : t);
            res = res | ((s & mask) << (l * L));
            if (t != s) e.v = 1'b1;
            if (l == nl - 1) begin
                e.n = (t < 0);
                e.c = o[0] ? (ua >= ub) : ((ua + ub) > mask);
            end
        end
        e.r = res[15:0];
        e.z = (res[15:0] == 16'h0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic nxt, ofire;
        if (rst) begin
            q.delete();
            exp_sticky = 1'b0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || out_ready});
            chk("sat_sticky", {31'b0, sat_sticky}, {31'b0, exp_sticky});
            if (out_valid) chk("out_valid_with_beat", q.size(), (q.size() > 0) ? q.size() : 1);
            ofire = out_valid && out_ready;
            nxt   = exp_sticky;
            if (ofire && q.size() > 0) begin
                e = q.pop_front();
                chk("result", {16'b0, result}, {16'b0, e.r});
                chk("flags_vnzc", {28'b0, v, n, z, c}, {28'b0, e.v, e.n, e.z, e.c});
                if (e.v) nxt = 1'b1;
                else if (clr_sat) nxt = 1'b0;
            end else if (clr_sat) begin
                nxt = 1'b0;
            end
            if (in_valid && in_ready) q.push_back(dir_valid ? dir_exp : model(op, a, b));
            exp_sticky = nxt;
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_sat   = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 59) chk("send_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] r, input logic [3:0] vnzc);
        dir_exp   = '{r: r, v: vnzc[3], n: vnzc[2], z: vnzc[1], c: vnzc[0]};
        dir_valid = 1'b1;
        send(o, x, y);
        dir_valid = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h7F80;
            3: return 16'h807F;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_result", {16'b0, result}, 0);
        chk("reset_flags", {28'b0, v, n, z, c}, 0);
        chk("reset_sticky", {31'b0, sat_sticky}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_dir(2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1000);
        @(negedge clk);
        chk("latency_stage1", {31'b0, out_valid}, 0);
        @(negedge clk);
        chk("latency_stage2", {31'b0, out_valid}, 1);
        @(posedge clk); #1;
        send_dir(2'b01, 16'h8000, 16'h0001, 16'h8000, 4'b1101);
        send_dir(2'b10, 16'h7F80, 16'h01FF, 16'h7F80, 4'b1000);
        send_dir(2'b11, 16'h0505, 16'h0506, 16'h00FF, 4'b0001);
        send_dir(2'b00, 16'h1234, 16'hEDCC, 16'h0000, 4'b0011);
        repeat (4) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send_dir(2'b00, 16'd1, 16'd1, 16'h0002, 4'b0000);
        send_dir(2'b00, 16'd2, 16'd2, 16'h0004, 4'b0000);
        op = 2'b00; a = 16'd3; b = 16'd3; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'b0, in_ready}, 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_dir(2'b00, 16'd3, 16'd3, 16'h0006, 4'b0000);
        @(negedge clk);
        chk("bp_drain_1", {31'b0, out_valid}, 1);
        @(negedge clk);
        chk("bp_drain_2", {31'b0, out_valid}, 1);
        @(negedge clk);
        chk("bp_bubble", {31'b0, out_valid}, 0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send_dir(2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1000);
        send_dir(2'b01, 16'h8000, 16'h0001, 16'h8000, 4'b1101);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_result", {16'b0, result}, 0);
        chk("rst_sticky", {31'b0, sat_sticky}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        send_dir(2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1000);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) break;
            if (t == 9) chk("wait_out_valid", 0, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        clr_sat   = 1'b1;
        @(posedge clk); #1;
        clr_sat = 1'b0;
        @(negedge clk);
        chk("set_beats_clear", {31'b0, sat_sticky}, 1);
        @(posedge clk); #1;
        clr_sat = 1'b1;
        @(posedge clk); #1;
        clr_sat = 1'b0;
        @(negedge clk);
        chk("clear_sticky", {31'b0, sat_sticky}, 0);
        @(posedge clk); #1;

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(2'($urandom_range(0, 3)), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        clr_sat   = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
